// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the PDP-8 memory port arbiter.
// Width macros normally come from the shared defines; the fallbacks keep this slice self-contained.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package mem_arb_pkg;

  localparam int unsigned ADDR_W = `ADDR_WIDTH;
  localparam int unsigned DATA_W = `DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} arb_state_e;

  typedef enum logic [1:0] {GNT_NONE, GNT_IFU, GNT_EXEC_RD, GNT_EXEC_WR} arb_gnt_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled as one interface.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              ifu_rd_req;
  logic [ADDR_W-1:0] ifu_rd_addr;
  logic [DATA_W-1:0] ifu_rd_data;
  logic              ifu_ack;

  logic              exec_rd_req;
  logic [ADDR_W-1:0] exec_rd_addr;
  logic              exec_wr_req;
  logic [ADDR_W-1:0] exec_wr_addr;
  logic [DATA_W-1:0] exec_wr_data;
  logic [DATA_W-1:0] exec_rd_data;
  logic              exec_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              protocol_err;

  modport slave (
    input  ifu_rd_req, ifu_rd_addr,
    input  exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
    input  mem_rdata,
    output ifu_rd_data, ifu_ack, exec_rd_data, exec_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy, protocol_err
  );

  modport master (
    output ifu_rd_req, ifu_rd_addr,
    output exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
    output mem_rdata,
    input  ifu_rd_data, ifu_ack, exec_rd_data, exec_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, protocol_err
  );

endinterface

// File: rtl/mem_arb_priority_sel.sv
// IDLE-state winner selection with a saturating IFD starvation counter.
// The counter only moves on the cycle a grant is actually taken.
module mem_arb_priority_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     ifu_rd_req_i,
  input  logic     exec_rd_req_i,
  input  logic     exec_wr_req_i,
  input  logic     gnt_take_i,
  output arb_gnt_e gnt_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;

  // A starved IFD overrides the normal exec-first ordering.
  always_comb begin
    gnt_o = GNT_NONE;
    if (ifu_rd_req_i && (starve_q == LIMIT)) begin
      gnt_o = GNT_IFU;
    end else if (exec_wr_req_i) begin
      gnt_o = GNT_EXEC_WR;
    end else if (exec_rd_req_i) begin
      gnt_o = GNT_EXEC_RD;
    end else if (ifu_rd_req_i) begin
      gnt_o = GNT_IFU;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt_take_i) begin
      if (gnt_o == GNT_IFU) begin
        starve_d = '0;
      end else if (ifu_rd_req_i && (starve_q != LIMIT)) begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the IFD read port and the exec read/write ports.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> ACK -> IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int LW = $clog2(RD_LATENCY + 1);
  localparam logic [LW-1:0] LAT_END = LW'(RD_LATENCY);

  arb_state_e        state_q, state_d;
  arb_gnt_e          gnt_q, gnt_d;
  arb_gnt_e          sel_gnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              perr_q, perr_d;
  logic              gnt_take;
  logic              granted_req;

  assign gnt_take = (state_q == IDLE) && (sel_gnt != GNT_NONE);

  mem_arb_priority_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sel (
    .clk           (clk),
    .reset_n       (reset_n),
    .ifu_rd_req_i  (bus.ifu_rd_req),
    .exec_rd_req_i (bus.exec_rd_req),
    .exec_wr_req_i (bus.exec_wr_req),
    .gnt_take_i    (gnt_take),
    .gnt_o         (sel_gnt)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (gnt_take) begin
          gnt_d   = sel_gnt;
          state_d = ISSUE;
          wdata_d = '0;
          case (sel_gnt)
            GNT_IFU:     addr_d = bus.ifu_rd_addr;
            GNT_EXEC_RD: addr_d = bus.exec_rd_addr;
            GNT_EXEC_WR: begin
              addr_d  = bus.exec_wr_addr;
              wdata_d = bus.exec_wr_data;
            end
            default:     addr_d = addr_q;
          endcase
        end
      end
      ISSUE: begin
        lat_d   = LW'(1);
        state_d = (gnt_q == GNT_EXEC_WR) ? ACK : WAIT;
      end
      WAIT: begin
        // The last counted cycle is the one where memory presents valid data.
        if (lat_q == LAT_END) begin
          rdata_d = bus.mem_rdata;
          state_d = ACK;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    granted_req = 1'b1;
    case (gnt_q)
      GNT_IFU:     granted_req = bus.ifu_rd_req;
      GNT_EXEC_RD: granted_req = bus.exec_rd_req;
      GNT_EXEC_WR: granted_req = bus.exec_wr_req;
      default:     granted_req = 1'b1;
    endcase
  end

  // Sticky: both exec strobes at once, or the owner letting go before its ack.
  assign perr_d = perr_q
                | (bus.exec_rd_req && bus.exec_wr_req)
                | (((state_q == ISSUE) || (state_q == WAIT)) && !granted_req);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= GNT_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.mem_req      = (state_q == ISSUE);
  assign bus.mem_we       = bus.mem_req && (gnt_q == GNT_EXEC_WR);
  assign bus.mem_addr     = bus.mem_req ? addr_q : '0;
  assign bus.mem_wdata    = bus.mem_req ? wdata_q : '0;

  assign bus.ifu_ack      = (state_q == ACK) && (gnt_q == GNT_IFU);
  assign bus.exec_ack     = (state_q == ACK) && ((gnt_q == GNT_EXEC_RD) || (gnt_q == GNT_EXEC_WR));
  assign bus.ifu_rd_data  = bus.ifu_ack ? rdata_q : '0;
  assign bus.exec_rd_data = ((state_q == ACK) && (gnt_q == GNT_EXEC_RD)) ? rdata_q : '0;

  assign bus.busy         = (state_q != IDLE);
  assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one DUT at default latency, one at RD_LATENCY=3,
// each backed by a small latency-accurate memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus3 ();

  mem_port_arbiter #(.RD_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  mem_port_arbiter #(.RD_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus3)
  );

  // Memory behind the default DUT: data valid one cycle after the mem_req cycle, all-ones otherwise.
  logic [DATA_W-1:0] mem [0:4095];
  logic [DATA_W-1:0] pipe1;
  logic              v1;

  always @(posedge clk) begin
    v1    <= bus.mem_req && !bus.mem_we;
    pipe1 <= mem[bus.mem_addr];
    if (bus.mem_req && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = v1 ? pipe1 : '1;

  // Memory behind the RD_LATENCY=3 DUT: data valid three cycles after the mem_req cycle.
  logic [DATA_W-1:0] mem3 [0:4095];
  logic [DATA_W-1:0] pipe3 [3];
  logic [2:0]        v3;

  always @(posedge clk) begin
    v3       <= {v3[1:0], bus3.mem_req && !bus3.mem_we};
    pipe3[0] <= mem3[bus3.mem_addr];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign bus3.mem_rdata = v3[2] ? pipe3[2] : '1;

  int nChecks = 0;
  int nFail   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  int               nReq;
  int               nIfuAck;
  int               nExecAck;
  logic [ADDR_W-1:0] seq [8];

  initial begin
    reset_n = 1'b0;
    bus.ifu_rd_req   = 1'b0; bus.ifu_rd_addr  = '0;
    bus.exec_rd_req  = 1'b0; bus.exec_rd_addr = '0;
    bus.exec_wr_req  = 1'b0; bus.exec_wr_addr = '0; bus.exec_wr_data = '0;
    bus3.ifu_rd_req  = 1'b0; bus3.ifu_rd_addr  = '0;
    bus3.exec_rd_req = 1'b0; bus3.exec_rd_addr = '0;
    bus3.exec_wr_req = 1'b0; bus3.exec_wr_addr = '0; bus3.exec_wr_data = '0;
    for (int i = 0; i < 8; i++) seq[i] = '0;
    mem[12'o0200]  = 12'o7402;
    mem[12'o0010]  = 12'o2222;
    mem[12'o0400]  = 12'o1111;
    mem3[12'o0010] = 12'o1234;

    $display("[TB] reset state");
    applyStimulus(2);
    checkOutput("rst_busy",     bus.busy,         0);
    checkOutput("rst_mem_req",  bus.mem_req,      0);
    checkOutput("rst_ifu_ack",  bus.ifu_ack,      0);
    checkOutput("rst_exec_ack", bus.exec_ack,     0);
    checkOutput("rst_perr",     bus.protocol_err, 0);
    checkOutput("rst3_busy",    bus3.busy,        0);
    reset_n = 1'b1;
    applyStimulus(1);

    $display("[TB] reset during WAIT discards the read");
    bus.ifu_rd_addr = 12'o0200; bus.ifu_rd_req = 1'b1;
    applyStimulus(1);
    checkOutput("midrst_issue", bus.mem_req, 1);
    applyStimulus(1);
    checkOutput("midrst_wait_busy", bus.busy, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy",     bus.busy,        0);
    checkOutput("midrst_mem_req",  bus.mem_req,     0);
    checkOutput("midrst_mem_addr", bus.mem_addr,    0);
    checkOutput("midrst_ifu_ack",  bus.ifu_ack,     0);
    checkOutput("midrst_ifu_data", bus.ifu_rd_data, 0);
    bus.ifu_rd_req = 1'b0;
    applyStimulus(1);
    checkOutput("midrst_no_ack", bus.ifu_ack, 0);
    reset_n = 1'b1;
    applyStimulus(1);
    checkOutput("midrst_no_late_ack", bus.ifu_ack, 0);

    $display("[TB] fresh IFD read after reset");
    bus.ifu_rd_addr = 12'o0200; bus.ifu_rd_req = 1'b1;
    applyStimulus(1);
    checkOutput("rd_c1_req",  bus.mem_req,  1);
    checkOutput("rd_c1_we",   bus.mem_we,   0);
    checkOutput("rd_c1_addr", bus.mem_addr, 12'o0200);
    applyStimulus(1);
    checkOutput("rd_c2_ack",  bus.ifu_ack,  0);
    applyStimulus(1);
    checkOutput("rd_c3_ack",  bus.ifu_ack,     1);
    checkOutput("rd_c3_data", bus.ifu_rd_data, 12'o7402);
    checkOutput("rd_c3_xack", bus.exec_ack,    0);
    bus.ifu_rd_req = 1'b0;
    applyStimulus(1);
    checkOutput("rd_c4_busy", bus.busy,        0);
    checkOutput("rd_c4_data", bus.ifu_rd_data, 0);

    $display("[TB] exec write");
    bus.exec_wr_addr = 12'o0300; bus.exec_wr_data = 12'o5555; bus.exec_wr_req = 1'b1;
    applyStimulus(1);
    checkOutput("wr_c1_req",   bus.mem_req,   1);
    checkOutput("wr_c1_we",    bus.mem_we,    1);
    checkOutput("wr_c1_addr",  bus.mem_addr,  12'o0300);
    checkOutput("wr_c1_wdata", bus.mem_wdata, 12'o5555);
    checkOutput("wr_c1_ack",   bus.exec_ack,  0);
    applyStimulus(1);
    checkOutput("wr_c2_ack",   bus.exec_ack,  1);
    checkOutput("wr_c2_req",   bus.mem_req,   0);
    checkOutput("wr_c2_addr",  bus.mem_addr,  0);
    checkOutput("wr_c2_wdata", bus.mem_wdata, 0);
    checkOutput("wr_c2_iack",  bus.ifu_ack,   0);
    bus.exec_wr_req = 1'b0;
    applyStimulus(1);
    checkOutput("wr_c3_busy",  bus.busy,      0);

    $display("[TB] exec read with RD_LATENCY=3");
    bus3.exec_rd_addr = 12'o0010; bus3.exec_rd_req = 1'b1;
    applyStimulus(1);
    checkOutput("lat_c1_req",  bus3.mem_req,  1);
    checkOutput("lat_c1_we",   bus3.mem_we,   0);
    checkOutput("lat_c1_addr", bus3.mem_addr, 12'o0010);
    for (int c = 2; c <= 4; c++) begin
      applyStimulus(1);
      checkOutput("lat_wait_ack", bus3.exec_ack, 0);
      checkOutput("lat_wait_req", bus3.mem_req,  0);
    end
    applyStimulus(1);
    checkOutput("lat_c5_ack",  bus3.exec_ack,     1);
    checkOutput("lat_c5_data", bus3.exec_rd_data, 12'o1234);
    bus3.exec_rd_req = 1'b0;
    applyStimulus(1);
    checkOutput("lat_c6_ack",  bus3.exec_ack,     0);
    checkOutput("lat_c6_data", bus3.exec_rd_data, 0);

    $display("[TB] priority: exec before IFD, IFD reads back the earlier write");
    bus.ifu_rd_addr  = 12'o0300; bus.ifu_rd_req  = 1'b1;
    bus.exec_rd_addr = 12'o0010; bus.exec_rd_req = 1'b1;
    applyStimulus(1);
    checkOutput("pri_first_addr", bus.mem_addr, 12'o0010);
    applyStimulus(2);
    checkOutput("pri_exec_ack",  bus.exec_ack,     1);
    checkOutput("pri_exec_data", bus.exec_rd_data, 12'o2222);
    checkOutput("pri_ifu_wait",  bus.ifu_ack,      0);
    bus.exec_rd_req = 1'b0;
    applyStimulus(1);
    checkOutput("pri_gap_busy",  bus.busy, 0);
    applyStimulus(1);
    checkOutput("pri_second_addr", bus.mem_addr, 12'o0300);
    applyStimulus(2);
    checkOutput("pri_ifu_ack",  bus.ifu_ack,     1);
    checkOutput("pri_ifu_data", bus.ifu_rd_data, 12'o5555);
    bus.ifu_rd_req = 1'b0;
    applyStimulus(1);

    $display("[TB] starvation bound");
    nReq = 0; nIfuAck = 0; nExecAck = 0;
    bus.ifu_rd_addr  = 12'o0400; bus.ifu_rd_req  = 1'b1;
    bus.exec_rd_addr = 12'o0010; bus.exec_rd_req = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      applyStimulus(1);
      if (bus.mem_req) begin
        if (nReq < 8) seq[nReq] = bus.mem_addr;
        nReq++;
      end
      if (bus.ifu_ack)  nIfuAck++;
      if (bus.exec_ack) nExecAck++;
    end
    bus.ifu_rd_req = 1'b0; bus.exec_rd_req = 1'b0;
    checkOutput("starve_nreq",  nReq, 6);
    checkOutput("starve_g0",    seq[0], 12'o0010);
    checkOutput("starve_g1",    seq[1], 12'o0010);
    checkOutput("starve_g2",    seq[2], 12'o0010);
    checkOutput("starve_g3",    seq[3], 12'o0010);
    checkOutput("starve_g4",    seq[4], 12'o0400);
    checkOutput("starve_g5",    seq[5], 12'o0010);
    checkOutput("starve_nifu",  nIfuAck, 1);
    checkOutput("starve_nexec", nExecAck, 5);
    applyStimulus(1);
    checkOutput("starve_idle", bus.busy,         0);
    checkOutput("starve_perr", bus.protocol_err, 0);

    $display("[TB] protocol error: simultaneous exec read and write");
    bus.exec_wr_addr = 12'o0500; bus.exec_wr_data = 12'o0123; bus.exec_wr_req = 1'b1;
    bus.exec_rd_addr = 12'o0010; bus.exec_rd_req = 1'b1;
    applyStimulus(1);
    checkOutput("perr1_we",   bus.mem_we,       1);
    checkOutput("perr1_addr", bus.mem_addr,     12'o0500);
    checkOutput("perr1_flag", bus.protocol_err, 1);
    applyStimulus(1);
    checkOutput("perr1_wack", bus.exec_ack, 1);
    bus.exec_wr_req = 1'b0;
    applyStimulus(2);
    checkOutput("perr1_rd_req",  bus.mem_req,  1);
    checkOutput("perr1_rd_we",   bus.mem_we,   0);
    checkOutput("perr1_rd_addr", bus.mem_addr, 12'o0010);
    applyStimulus(2);
    checkOutput("perr1_rack", bus.exec_ack,     1);
    checkOutput("perr1_data", bus.exec_rd_data, 12'o2222);
    bus.exec_rd_req = 1'b0;
    applyStimulus(1);
    checkOutput("perr1_sticky", bus.protocol_err, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("perr1_cleared", bus.protocol_err, 0);
    applyStimulus(1);
    reset_n = 1'b1;
    applyStimulus(1);

    $display("[TB] protocol error: IFD drops request in WAIT");
    bus.ifu_rd_addr = 12'o0400; bus.ifu_rd_req = 1'b1;
    applyStimulus(2);
    checkOutput("perr2_before", bus.protocol_err, 0);
    bus.ifu_rd_req = 1'b0;
    applyStimulus(1);
    checkOutput("perr2_ack",  bus.ifu_ack,      1);
    checkOutput("perr2_data", bus.ifu_rd_data,  12'o1111);
    checkOutput("perr2_flag", bus.protocol_err, 1);
    applyStimulus(1);
    checkOutput("perr2_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
